cycle_right_deserializer: RTL

- Serial-in, parallel-out receiver; the counterpart of the team's parallel-load cycle-left shift register.
- Accepts one bit per qualified clock, LSB first, and shifts each bit in from the MSB end (right shift).
- After MSB bits it presents the assembled word on a one-deep valid/ready output buffer.
- Sits between a serial bit source and a parallel consumer; reports dropped words and frame progress.

---
 rtl/cycle_right_deserializer_pkg.sv | 9 +
 rtl/cycle_right_deserializer_out_hold_buf.sv | 45 ++++
 rtl/cycle_right_deserializer.sv | 94 +++++++++
 3 files changed

// File: rtl/cycle_right_deserializer_pkg.sv
// Shared types for the cycle-right deserializer: frame FSM state encoding.
package cycle_right_deserializer_pkg;

  typedef enum logic {
    StIdle  = 1'b0,
    StShift = 1'b1
  } state_e;

endpackage

// File: rtl/cycle_right_deserializer_out_hold_buf.sv
// One-deep valid/ready holding register; refills in the same cycle it is drained.
module cycle_right_deserializer_out_hold_buf #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] data,
  input  logic         ready,
  output logic [W-1:0] dout,
  output logic         o_valid,
  output logic         drop
);

  logic [W-1:0] dout_q, dout_d;
  logic         valid_q, valid_d;
  logic         transfer;

  always_comb begin
    transfer = load & (~valid_q | ready);
    drop     = load & valid_q & ~ready;
    dout_d   = dout_q;
    valid_d  = valid_q;
    if (transfer) begin
      dout_d  = data;
      valid_d = 1'b1;
    end else if (ready & valid_q) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  assign dout    = dout_q;
  assign o_valid = valid_q;

endmodule

// File: rtl/cycle_right_deserializer.sv
// Serial-in parallel-out receiver: LSB-first bits enter at the MSB end and
// complete words are handed to a one-deep output buffer.
module cycle_right_deserializer
  import cycle_right_deserializer_pkg::*;
#(
  parameter int unsigned MSB   = 4,
  parameter int unsigned CNT_W = $clog2(MSB)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic             din,
  input  logic             i_clear,
  input  logic             i_ready,
  output logic [MSB-1:0]   dout,
  output logic             o_valid,
  output logic             o_overrun,
  output logic [CNT_W-1:0] o_bit_cnt
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(MSB - 1);

  state_e           state_q, state_d;
  logic [MSB-1:0]   sreg_q, sreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             overrun_q;
  logic             word_done;
  logic             drop;
  logic [MSB-1:0]   word;

  assign word = {din, sreg_q[MSB-1:1]};

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    cnt_d     = cnt_q;
    word_done = 1'b0;
    if (i_clear) begin
      // Clear wins over a coincident bit, which is discarded.
      state_d = StIdle;
      sreg_d  = '0;
      cnt_d   = '0;
    end else if (i_valid) begin
      sreg_d = word;
      unique case (state_q)
        StIdle: begin
          cnt_d   = CNT_W'(1);
          state_d = StShift;
        end
        StShift: begin
          if (cnt_q == LastCnt) begin
            cnt_d     = '0;
            word_done = 1'b1;
            state_d   = StIdle;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= StIdle;
      sreg_q    <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_q | drop;
    end
  end

  cycle_right_deserializer_out_hold_buf #(
    .W (MSB)
  ) u_out_hold_buf (
    .clk     (i_clk),
    .rst     (i_rst),
    .load    (word_done),
    .data    (word),
    .ready   (i_ready),
    .dout    (dout),
    .o_valid (o_valid),
    .drop    (drop)
  );

  assign o_overrun = overrun_q;
  assign o_bit_cnt = cnt_q;

endmodule
